// File: rtl/bus_fifo_periph_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_fifo_periph_if
// Brief    : Word bus between bus_cdc and bus_fifo_periph. The bus side drives
//            address/data/write strobe; the peripheral returns combinational
//            read data and a busy flag.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_fifo_periph_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [31:0]           address_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  we_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  module_busy_o;

    // Bus side (bus_cdc or a testbench)
    modport master (
        output address_i,
        output data_i,
        output we_i,
        input  data_o,
        input  module_busy_o
    );

    // Peripheral side
    modport slave (
        input  address_i,
        input  data_i,
        input  we_i,
        output data_o,
        output module_busy_o
    );
endinterface
`default_nettype wire

// File: rtl/bus_fifo_periph.sv
`default_nettype none
// ============================================================================
// Module   : bus_fifo_periph
// Brief    : Memory-mapped FIFO peripheral. PUSH/POP/STATUS/CTRL registers at
//            BASE_ADDR + 0x0..0x10. The head word is held in a register that
//            is refilled from the FIFO memory in a one-cycle PREFETCH state,
//            during which module_busy_o is high and bus writes are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module bus_fifo_periph #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          DEPTH      = 16,   // power of two, 2..256
    parameter int          DATA_WIDTH = 32    // must hold STATUS (>= 16+log2(DEPTH)+1)
) (
    input wire             clk_i,
    input wire             reset_i,
    bus_fifo_periph_if.slave bus
);

    localparam int c_AW = $clog2(DEPTH);  // pointer width
    localparam int c_CW = c_AW + 1;       // count width, holds 0..DEPTH

    localparam logic [c_AW-1:0] c_PTR_ONE   = c_AW'(1);
    localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
    localparam logic [c_CW-1:0] c_CNT_DEPTH = c_CW'(DEPTH);

    // Register offsets relative to BASE_ADDR
    localparam logic [31:0] c_OFF_PUSH   = 32'h0000_0000;
    localparam logic [31:0] c_OFF_HEAD   = 32'h0000_0004;
    localparam logic [31:0] c_OFF_POP    = 32'h0000_0008;
    localparam logic [31:0] c_OFF_STATUS = 32'h0000_000C;
    localparam logic [31:0] c_OFF_CTRL   = 32'h0000_0010;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_PREFETCH = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_CW-1:0]       r_count;
    logic [DATA_WIDTH-1:0] r_head;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [31:0]           w_off;
    logic                  w_hit_push;
    logic                  w_hit_head;
    logic                  w_hit_pop;
    logic                  w_hit_status;
    logic                  w_hit_ctrl;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_mem_we;
    logic [DATA_WIDTH-1:0] w_status;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Address decode: only exact word offsets hit; anything else is unmapped
    assign w_off        = bus.address_i - BASE_ADDR;
    assign w_hit_push   = (w_off == c_OFF_PUSH);
    assign w_hit_head   = (w_off == c_OFF_HEAD);
    assign w_hit_pop    = (w_off == c_OFF_POP);
    assign w_hit_status = (w_off == c_OFF_STATUS);
    assign w_hit_ctrl   = (w_off == c_OFF_CTRL);

    assign w_full  = (r_count == c_CNT_DEPTH);
    assign w_empty = (r_count == '0);

    // A memory write happens only for an accepted push; reset and PREFETCH block it
    assign w_mem_we = !reset_i && (r_state == S_IDLE) && bus.we_i && w_hit_push && !w_full;

    // Assemble the STATUS word: count in the upper half, flags in the low nibble
    always_comb begin
        w_status               = '0;
        w_status[16 +: c_CW]   = r_count;
        w_status[3]            = w_full;
        w_status[2]            = w_empty;
        w_status[1]            = r_underflow;
        w_status[0]            = r_overflow;
    end

    // Read mux: HEAD reads 0 when the FIFO is empty, write-only/unmapped read 0
    always_comb begin
        w_rdata = '0;
        if (w_hit_head && !w_empty) begin
            w_rdata = r_head;
        end else if (w_hit_status) begin
            w_rdata = w_status;
        end
    end

    assign bus.data_o        = w_rdata;
    assign bus.module_busy_o = r_busy;

    // FIFO storage; contents are never reset, validity is tracked by count
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= bus.data_i;
        end
    end

    // Control FSM: pointers, count, head register, sticky flags and busy
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_head      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.we_i && w_hit_push) begin
                        if (!w_full) begin
                            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                            r_count  <= r_count + c_CNT_ONE;
                            // First word into an empty FIFO must be fetched into head
                            if (w_empty) begin
                                r_state <= S_PREFETCH;
                                r_busy  <= 1'b1;
                            end
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end else if (bus.we_i && w_hit_pop) begin
                        if (!w_empty) begin
                            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                            r_count  <= r_count - c_CNT_ONE;
                            if (r_count != c_CNT_ONE) begin
                                r_state <= S_PREFETCH;
                                r_busy  <= 1'b1;
                            end else begin
                                r_head <= '0;
                            end
                        end else begin
                            r_underflow <= 1'b1;
                        end
                    end else if (bus.we_i && w_hit_status) begin
                        // Write-one-to-clear on the two sticky error flags
                        if (bus.data_i[0]) begin
                            r_overflow <= 1'b0;
                        end
                        if (bus.data_i[1]) begin
                            r_underflow <= 1'b0;
                        end
                    end else if (bus.we_i && w_hit_ctrl && bus.data_i[0]) begin
                        // Flush: empty the FIFO logically, memory left as is
                        r_wr_ptr    <= '0;
                        r_rd_ptr    <= '0;
                        r_count     <= '0;
                        r_head      <= '0;
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                    end
                end
                S_PREFETCH: begin
                    // rd_ptr already points at the new head; no write can race it
                    r_head  <= r_mem[r_rd_ptr];
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_fifo_periph.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_fifo_periph
// Brief    : Directed self-checking bench for bus_fifo_periph with a queue
//            scoreboard of expected FIFO contents and a flag model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_fifo_periph;

    localparam logic [31:0] c_BASE  = 32'h4000_0100;
    localparam int          c_DEPTH = 16;
    localparam int          c_DW    = 32;

    localparam logic [31:0] c_PUSH   = 32'h00;
    localparam logic [31:0] c_HEAD   = 32'h04;
    localparam logic [31:0] c_POP    = 32'h08;
    localparam logic [31:0] c_STATUS = 32'h0C;
    localparam logic [31:0] c_CTRL   = 32'h10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_fifo_periph_if #(.DATA_WIDTH(c_DW)) bus ();

    bus_fifo_periph #(
        .BASE_ADDR (c_BASE),
        .DEPTH     (c_DEPTH),
        .DATA_WIDTH(c_DW)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb[$];
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s        = '0;
        s[20:16] = 5'(sb.size());
        s[3]     = (sb.size() == c_DEPTH);
        s[2]     = (sb.size() == 0);
        s[1]     = m_udf;
        s[0]     = m_ovf;
        return s;
    endfunction

    task automatic rd(input logic [31:0] off, output logic [31:0] d);
        bus.we_i      = 1'b0;
        bus.address_i = c_BASE + off;
        #1;
        d = bus.data_o;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        @(negedge clk);
        bus.address_i = c_BASE + off;
        bus.data_i    = d;
        bus.we_i      = 1'b1;
        @(negedge clk);
        bus.we_i      = 1'b0;
    endtask

    task automatic check_busy(input string tag, input logic exp);
        check(tag, {31'b0, bus.module_busy_o}, {31'b0, exp});
    endtask

    task automatic check_status(input string tag);
        logic [31:0] v;
        rd(c_STATUS, v);
        check(tag, v, exp_status());
    endtask

    task automatic push(input logic [31:0] d, input string tag);
        logic exp_busy;
        exp_busy = (sb.size() == 0);
        if (sb.size() < c_DEPTH) sb.push_back(d);
        else                     m_ovf = 1'b1;
        wr(c_PUSH, d);
        check_busy({tag, "_busy"}, exp_busy);
        if (exp_busy) begin
            @(negedge clk);
            check_busy({tag, "_busyfall"}, 1'b0);
        end
        check_status({tag, "_status"});
    endtask

    task automatic pop(input string tag);
        logic [31:0] v;
        logic [31:0] exp_head;
        logic        exp_busy;
        rd(c_HEAD, v);
        exp_head = (sb.size() > 0) ? sb[0] : 32'h0;
        check({tag, "_head"}, v, exp_head);
        wr(c_POP, 32'hDEAD_BEEF);
        if (sb.size() > 0) begin
            void'(sb.pop_front());
            exp_busy = (sb.size() > 0);
        end else begin
            m_udf    = 1'b1;
            exp_busy = 1'b0;
        end
        check_busy({tag, "_busy"}, exp_busy);
        if (exp_busy) begin
            @(negedge clk);
            check_busy({tag, "_busyfall"}, 1'b0);
        end
        check_status({tag, "_status"});
    endtask

    // Hard stop if the sequence never completes
    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Directed sequence
    initial begin
        logic [31:0] v;
        bus.we_i      = 1'b0;
        bus.address_i = c_BASE;
        bus.data_i    = '0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        rd(c_STATUS, v); check("rst_status", v, 32'h0000_0004);
        rd(c_HEAD, v);   check("rst_head", v, 32'h0);
        check_busy("rst_busy", 1'b0);

        // Push to empty: busy one cycle, head valid afterwards; second push no busy
        push(32'hA5A5_0001, "p1");
        rd(c_HEAD, v); check("p1_head", v, 32'hA5A5_0001);
        push(32'h0000_0002, "p2");
        rd(c_STATUS, v); check("p2_status_lit", v, 32'h0002_0000);
        pop("q1");
        pop("q2");
        rd(c_HEAD, v); check("q2_head_zero", v, 32'h0);

        // Fill past full, clear overflow, drain in order
        for (int i = 0; i < 17; i++) push(32'(i), "fill");
        rd(c_STATUS, v); check("full_status_lit", v, 32'h0010_0009);
        wr(c_STATUS, 32'h1); m_ovf = 1'b0;
        check_status("w1c_ovf");
        for (int i = 0; i < 16; i++) pop("drain");
        rd(c_HEAD, v); check("drain_head_zero", v, 32'h0);

        // Underflow, zero write keeps it, W1C clears it
        pop("under");
        wr(c_STATUS, 32'h0);
        check_status("w1c_zero");
        wr(c_STATUS, 32'h2); m_udf = 1'b0;
        check_status("w1c_udf");

        // A push issued while PREFETCH is running is dropped
        @(negedge clk);
        bus.address_i = c_BASE + c_PUSH;
        bus.data_i    = 32'h0000_00D1;
        bus.we_i      = 1'b1;
        @(negedge clk);
        check_busy("pf_busy", 1'b1);
        bus.data_i    = 32'h0000_00D2;
        @(negedge clk);
        bus.we_i      = 1'b0;
        sb.push_back(32'h0000_00D1);
        check_busy("pf_busyfall", 1'b0);
        check_status("pf_ignored");
        pop("pf_pop");

        // Unmapped / write-only / unaligned reads and an unmapped write
        push(32'h0000_0055, "um");
        rd(32'h14, v);   check("rd_unmapped", v, 32'h0);
        rd(c_PUSH, v);   check("rd_push", v, 32'h0);
        rd(32'h06, v);   check("rd_unaligned", v, 32'h0);
        wr(32'h14, 32'hFFFF_FFFF);
        wr(32'h02, 32'h1234_5678);
        check_status("wr_unmapped");
        pop("um_pop");

        // Pointer wrap: 10 in/10 out, then 12 in/12 out
        for (int i = 0; i < 10; i++) push(32'h200 + 32'(i), "w1");
        for (int i = 0; i < 10; i++) pop("w1");
        for (int i = 0; i < 12; i++) push(32'h100 + 32'(i), "w2");
        for (int i = 0; i < 12; i++) pop("w2");

        // Interleaved traffic
        push(32'hC0, "il"); push(32'hC1, "il"); pop("il");
        push(32'hC2, "il"); pop("il"); pop("il");

        // Flush with 5 entries and overflow set
        for (int i = 0; i < 17; i++) push(32'h300 + 32'(i), "fl");
        for (int i = 0; i < 11; i++) pop("fl");
        check_status("fl_pre");
        wr(c_CTRL, 32'h1);
        sb.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        rd(c_STATUS, v); check("fl_status", v, 32'h0000_0004);
        rd(c_HEAD, v);   check("fl_head", v, 32'h0);
        push(32'h0000_0ABC, "postfl");
        pop("postfl");

        // Reset during PREFETCH aborts it
        @(negedge clk);
        bus.address_i = c_BASE + c_PUSH;
        bus.data_i    = 32'h0000_0077;
        bus.we_i      = 1'b1;
        @(negedge clk);
        bus.we_i      = 1'b0;
        check_busy("rstpf_busy", 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        check_busy("rstpf_busy0", 1'b0);
        rd(c_STATUS, v); check("rstpf_status", v, 32'h0000_0004);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
